// File: rtl/ifu_fetch_if.sv
// -----------------------------------------------------------------------------
// ifu_fetch_if
// Purpose : Groups the signals between the instruction fetch unit and the
//           parts around it: the instruction-memory request/response bus,
//           the redirect input, the decoder handshake and the status outputs.
// Modports:
//   master - fetch unit side (drives imem_req/imem_addr, inst_valid/inst,
//            pc, halt; receives memory response, redirect and inst_ready)
//   slave  - environment side (memory, branch unit, decoder)
// Signals :
//   imem_req       fetch request to instruction memory
//   imem_addr[32]  fetch address, always equal to pc
//   imem_gnt       memory accepts the request this cycle
//   imem_rvalid    imem_rdata valid this cycle
//   imem_rdata[32] fetched instruction word
//   redirect_valid jump/branch redirect request
//   redirect_pc[32] redirect target address
//   inst_valid     inst holds a fetched word for the decoder
//   inst_ready     decoder consumes inst this cycle
//   inst[32]       registered instruction word
//   pc[32]         address of the word in flight or held
//   halt           fetch stopped
// -----------------------------------------------------------------------------
interface ifu_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        halt;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, pc, halt,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, pc, halt,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
// Purpose : Single-outstanding-request instruction fetch unit. Issues one
//           fetch at pc, waits for the response, holds the word for the
//           decoder, then advances pc by 4. Redirects replace pc (word
//           aligned) from any active state; a response that belongs to an
//           abandoned fetch is swallowed in DROP.
// Ports   :
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   io_bus - ifu_fetch_if.master (memory bus, redirect, decoder handshake,
//            pc and halt status)
// Option  : IFU_EBREAK_HALT_EN - when defined, consuming an ebreak word
//           (0x0010_0073) enters HALT, which is left only by reset. When
//           undefined, halt is tied to 0 and ebreak is an ordinary word.
// -----------------------------------------------------------------------------
module ifu_fetch (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   io_bus
);

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IFU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
`endif

`ifdef IFU_EBREAK_HALT_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4,
        S_HALT = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_inst;
    logic [31:0] w_inst_next;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;

    // Redirect targets are forced to a word boundary.
    assign w_redirect_pc = io_bus.redirect_pc & ~32'h0000_0003;
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign w_pc_inc      = r_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_inst  <= w_inst_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_inst_next  = r_inst;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                if (io_bus.redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end
            end

            S_REQ: begin
                if (io_bus.redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                    // A grant in the redirect cycle still commits memory to
                    // a response, which must be swallowed.
                    w_state_next = io_bus.imem_gnt ? S_DROP : S_REQ;
                end else if (io_bus.imem_gnt) begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (io_bus.redirect_valid) begin
                    w_pc_next    = w_redirect_pc;
                    // Response arriving with the redirect is simply dropped;
                    // otherwise it is still owed and DROP absorbs it.
                    w_state_next = io_bus.imem_rvalid ? S_REQ : S_DROP;
                end else if (io_bus.imem_rvalid) begin
                    w_inst_next  = io_bus.imem_rdata;
                    w_state_next = S_HOLD;
                end
            end

            S_HOLD: begin
                if (io_bus.redirect_valid) begin
                    w_pc_next    = w_redirect_pc;
                    w_state_next = S_REQ;
                end else if (io_bus.inst_ready) begin
`ifdef IFU_EBREAK_HALT_EN
                    if (r_inst == EBREAK) begin
                        w_state_next = S_HALT;
                    end else begin
                        w_pc_next    = w_pc_inc;
                        w_state_next = S_REQ;
                    end
`else
                    w_pc_next    = w_pc_inc;
                    w_state_next = S_REQ;
`endif
                end
            end

            S_DROP: begin
                if (io_bus.redirect_valid) begin
                    // Stay: the stale response is still outstanding.
                    w_pc_next = w_redirect_pc;
                end else if (io_bus.imem_rvalid) begin
                    w_state_next = S_REQ;
                end
            end

`ifdef IFU_EBREAK_HALT_EN
            S_HALT: begin
                w_state_next = S_HALT;
            end
`endif

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign io_bus.imem_req   = (r_state == S_REQ);
    assign io_bus.inst_valid = (r_state == S_HOLD);
    assign io_bus.imem_addr  = r_pc;
    assign io_bus.pc         = r_pc;
    assign io_bus.inst       = r_inst;
`ifdef IFU_EBREAK_HALT_EN
    assign io_bus.halt       = (r_state == S_HALT);
`else
    assign io_bus.halt       = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch
// Purpose : Self-checking bench for ifu_fetch. A behavioural model tracks
//           the fetch unit as a set of facts (fresh out of reset, a granted
//           fetch awaiting its response, whether that response is stale,
//           a word held for the decoder, halted) and predicts the outputs
//           after every clock. Directed scenarios run first, then random
//           traffic including random resets.
// -----------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef IFU_EBREAK_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_fresh;
    bit          m_awaiting;
    bit          m_stale;
    bit          m_holding;
    bit          m_halted;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_req();
        return !m_fresh && !m_awaiting && !m_holding && !m_halted;
    endfunction

    task automatic model_reset();
        m_pc       = 32'h8000_0000;
        m_inst     = 32'h0000_0000;
        m_fresh    = 1'b1;
        m_awaiting = 1'b0;
        m_stale    = 1'b0;
        m_holding  = 1'b0;
        m_halted   = 1'b0;
    endtask

    task automatic model_step(input bit g, input bit v, input logic [31:0] d,
                              input bit rv, input logic [31:0] rp, input bit rdy);
        bit req_now;
        bit aw;
        bit st;
        bit hold;
        req_now = model_req();
        aw      = m_awaiting;
        st      = m_stale;
        hold    = m_holding;
        if (m_halted) return;
        m_fresh = 1'b0;
        if (rv) begin
            m_pc = {rp[31:2], 2'b00};
            if (req_now && g) begin
                m_awaiting = 1'b1;
                m_stale    = 1'b1;
            end else if (aw && !st) begin
                if (v) m_awaiting = 1'b0;
                else   m_stale    = 1'b1;
            end
            m_holding = 1'b0;
        end else begin
            if (req_now && g) begin
                m_awaiting = 1'b1;
                m_stale    = 1'b0;
            end else if (aw && v) begin
                m_awaiting = 1'b0;
                if (!st) begin
                    m_holding = 1'b1;
                    m_inst    = d;
                end
            end else if (hold && rdy) begin
                m_holding = 1'b0;
                $display("txn consume pc=%h inst=%h", m_pc, m_inst);
                if (HALT_EN && m_inst == EBREAK) m_halted = 1'b1;
                else                             m_pc     = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model,
    // then compare every output at the next falling edge.
    task automatic cycle(input bit r, input bit g, input bit v, input logic [31:0] d,
                         input bit rv, input logic [31:0] rp, input bit rdy);
        rst                = r;
        bus.imem_gnt       = g;
        bus.imem_rvalid    = v;
        bus.imem_rdata     = d;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.inst_ready     = rdy;
        if (r) begin
            model_reset();
            #1;
            check_val("rst_req",    {31'd0, bus.imem_req},   32'd0);
            check_val("rst_ivalid", {31'd0, bus.inst_valid}, 32'd0);
            check_val("rst_pc",     bus.pc,                  32'h8000_0000);
        end else begin
            model_step(g, v, d, rv, rp, rdy);
        end
        @(posedge clk);
        @(negedge clk);
        check_val("req",    {31'd0, bus.imem_req},   {31'd0, model_req()});
        check_val("addr",   bus.imem_addr,           m_pc);
        check_val("pc",     bus.pc,                  m_pc);
        check_val("ivalid", {31'd0, bus.inst_valid}, {31'd0, m_holding});
        check_val("inst",   bus.inst,                m_inst);
        check_val("halt",   {31'd0, bus.halt},       {31'd0, m_halted});
    endtask

    initial begin
        rst                = 1'b1;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.inst_ready     = 1'b0;
        model_reset();
        @(negedge clk);

        // Basic fetch with minimum latency.
        cycle(1, 0, 0, 32'd0, 0, 32'd0, 0);
        check_val("idle_req", {31'd0, bus.imem_req}, 32'd0);
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 0);
        check_val("first_addr", bus.imem_addr, 32'h8000_0000);
        cycle(0, 1, 0, 32'd0, 0, 32'd0, 0);
        cycle(0, 0, 1, 32'h1111_0001, 0, 32'd0, 0);
        check_val("lat2_ivalid", {31'd0, bus.inst_valid}, 32'd1);
        check_val("lat2_inst", bus.inst, 32'h1111_0001);
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 1);
        check_val("next_addr", bus.imem_addr, 32'h8000_0004);

        // Decoder stalls in HOLD.
        cycle(0, 1, 0, 32'd0, 0, 32'd0, 0);
        cycle(0, 0, 1, 32'h2222_0002, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 32'h5555_5555, 0, 32'd0, 0);
            check_val("stall_inst", bus.inst, 32'h2222_0002);
            check_val("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 1);
        check_val("stall_pc", bus.pc, 32'h8000_0008);

        // Redirect in WAIT before the response: stale word swallowed.
        cycle(0, 1, 0, 32'd0, 0, 32'd0, 0);
        cycle(0, 0, 0, 32'd0, 1, 32'h8000_0103, 0);
        check_val("drop_req", {31'd0, bus.imem_req}, 32'd0);
        cycle(0, 0, 1, 32'hDEAD_BEEF, 0, 32'd0, 1);
        check_val("drop_ivalid", {31'd0, bus.inst_valid}, 32'd0);
        check_val("drop_inst", bus.inst, 32'h2222_0002);
        check_val("drop_addr", bus.imem_addr, 32'h8000_0100);

        // Redirect together with inst_ready in HOLD.
        cycle(0, 1, 0, 32'd0, 0, 32'd0, 0);
        cycle(0, 0, 1, 32'h3333_0003, 0, 32'd0, 0);
        cycle(0, 0, 0, 32'd0, 1, 32'h9000_0010, 1);
        check_val("hold_rd_pc", bus.pc, 32'h9000_0010);
        check_val("hold_rd_ivalid", {31'd0, bus.inst_valid}, 32'd0);

        // pc wrap at the top of the address space.
        cycle(0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC, 0);
        check_val("wrap_pre", bus.imem_addr, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 32'd0, 0, 32'd0, 0);
        cycle(0, 0, 1, 32'h4444_0004, 0, 32'd0, 0);
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 1);
        check_val("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // ebreak word.
        cycle(0, 1, 0, 32'd0, 0, 32'd0, 0);
        cycle(0, 0, 1, EBREAK, 0, 32'd0, 0);
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 1);
`ifdef IFU_EBREAK_HALT_EN
        check_val("ebrk_halt", {31'd0, bus.halt}, 32'd1);
        check_val("ebrk_pc", bus.pc, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 32'd0, 1, 32'h1234_5678, 1);
            check_val("halt_req", {31'd0, bus.imem_req}, 32'd0);
            check_val("halt_pc", bus.pc, 32'h0000_0000);
        end
`else
        check_val("ebrk_halt", {31'd0, bus.halt}, 32'd0);
        check_val("ebrk_addr", bus.imem_addr, 32'h0000_0004);
`endif
        cycle(1, 0, 0, 32'd0, 0, 32'd0, 0);
        check_val("final_rst_pc", bus.pc, 32'h8000_0000);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit          r;
            bit          g;
            bit          v;
            bit          rv;
            bit          rdy;
            logic [31:0] d;
            logic [31:0] rp;
            r   = ($urandom_range(0, 199) == 0);
            g   = ($urandom_range(0, 2) != 0);
            v   = ($urandom_range(0, 1) != 0);
            d   = ($urandom_range(0, 19) == 0) ? EBREAK : $urandom;
            rv  = ($urandom_range(0, 11) == 0);
            rp  = $urandom;
            rdy = ($urandom_range(0, 2) != 0);
            cycle(r, g, v, d, rv, rp, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width and meaning:
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; always equal to pc.
REQ-006 imem_gnt  input  1  memory accepts the request in this cycle.
REQ-007 imem_rvalid  input  1  imem_rdata is valid in this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  jump/branch redirect request.
REQ-010 redirect_pc  input  32  redirect target address.
REQ-011 inst_valid  output  1  inst holds a fetched word for the decoder.
REQ-012 inst_ready  input  1  decoder consumes inst in this cycle.
REQ-013 inst  output  32  registered instruction word for the decoder.
REQ-014 pc  output  32  address of the word that is in flight or held.
REQ-015 halt  output  1  fetch stopped; see Configuration.

Function
REQ-016 The block SHALL use these states: IDLE, REQ, WAIT, HOLD and DROP (plus HALT when the Configuration macro is defined).
REQ-017 imem_req SHALL be 1 only in REQ; inst_valid SHALL be 1 only in HOLD; both SHALL be driven combinationally from the state.
REQ-018 IDLE SHALL move to REQ unconditionally on the next edge.
REQ-019 REQ SHALL hold imem_addr stable until imem_gnt = 1, then move to WAIT.
REQ-020 WAIT on imem_rvalid = 1 SHALL capture imem_rdata into inst and move to HOLD.
REQ-021 HOLD on inst_ready = 1 SHALL set pc to pc + 4 and move to REQ; inst SHALL stay stable while the block waits in HOLD.
REQ-022 pc + 4 SHALL use 32-bit modulo arithmetic, so 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-023 Minimum latency: with grant in the first REQ cycle and rvalid in the next cycle, inst_valid SHALL assert 2 cycles after REQ entry; peak throughput is one instruction per 3 cycles.
REQ-024 redirect_valid SHALL override every other event in IDLE, REQ, WAIT, HOLD and DROP, and SHALL load pc with {redirect_pc[31:2], 2'b00}.
REQ-025 Redirect in IDLE, or in REQ without imem_gnt, SHALL go to REQ.
REQ-026 Redirect in REQ with imem_gnt, or in WAIT without imem_rvalid, SHALL go to DROP.
REQ-027 Redirect in WAIT with imem_rvalid, or in HOLD (inst_ready is ignored), SHALL discard the word, drop inst_valid on the next edge and go to REQ.
REQ-028 DROP SHALL discard the next imem_rvalid response and then go to REQ; a redirect during DROP SHALL update pc and keep the block in DROP.
REQ-029 imem_rvalid seen in IDLE, REQ or HOLD SHALL be ignored with no state change.

Reset
REQ-030 rst SHALL set state = IDLE, pc = 0x8000_0000, inst = 0x0000_0000 and halt = 0 asynchronously.
REQ-031 While in reset, imem_req = 0 and inst_valid = 0; a reset while a fetch is outstanding SHALL abandon that fetch with no pending response tracked.

Configuration
REQ-032 When the macro IFU_EBREAK_HALT_EN is defined, HOLD with inst = 0x0010_0073 and inst_ready = 1 SHALL move to HALT instead of REQ; pc does not advance.
REQ-033 HALT SHALL set halt = 1 and imem_req = 0, SHALL ignore redirect, and SHALL be left only by rst.
REQ-034 When IFU_EBREAK_HALT_EN is undefined, the halt port SHALL exist and be tied to 0, and ebreak SHALL be treated as an ordinary word.

Verification
REQ-035 Release reset; grant and rvalid each arrive on the first cycle offered -> imem_addr = 0x8000_0000; inst_valid = 1 two cycles after REQ entry; next request address = 0x8000_0004.
REQ-036 Hold inst_ready = 0 for 5 cycles in HOLD -> inst stays constant and no imem_req is issued; after ready, pc = old pc + 4.
REQ-037 Assert redirect to 0x8000_0103 in WAIT before rvalid -> DROP; the next rdata is not presented; the next request address = 0x8000_0100.
REQ-038 Assert redirect and inst_ready together in HOLD -> pc = the redirect target, inst_valid = 0 on the next cycle.
REQ-039 Set pc = 0xFFFF_FFFC via redirect and complete the fetch -> the next request address = 0x0000_0000.
REQ-040 With IFU_EBREAK_HALT_EN defined, fetch 0x0010_0073 and consume it -> halt = 1, no further imem_req, and redirect has no effect until rst.
